marin_keypad_scan: RTL and testbench

//  Input-side counterpart of the Marin 7-segment display driver: scans a Pmod KYPD 4x4 hex keypad.

---
 rtl/marin_keypad_scan_pkg.sv | 49 ++++
 rtl/marin_keypad_scan_if.sv | 23 ++
 rtl/marin_kypd_debounce.sv | 87 ++++++++
 rtl/marin_keypad_scan.sv | 147 ++++++++++++++
 tb/tb_marin_keypad_scan.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/marin_keypad_scan_pkg.sv
// Shared definitions for the Marin keypad scanner.
// Holds the keypad geometry, the hex code table (index = col*4 + row) and
// small helpers used by the debouncer and the encoder.
package marin_keypad_scan_pkg;

   localparam int unsigned KypdCols = 4;
   localparam int unsigned KypdRows = 4;
   localparam int unsigned KypdKeys = KypdCols * KypdRows;

   // Code table, row-major by row, columns 0..3:
   //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
   function automatic logic [3:0] key_code(input logic [3:0] idx);
      logic [3:0] code;
      unique case (idx)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h4;
         4'd2:    code = 4'h7;
         4'd3:    code = 4'h0;
         4'd4:    code = 4'h2;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h8;
         4'd7:    code = 4'hF;
         4'd8:    code = 4'h3;
         4'd9:    code = 4'h6;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hE;
         4'd12:   code = 4'hA;
         4'd13:   code = 4'hB;
         4'd14:   code = 4'hC;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   function automatic logic is_onehot(input logic [KypdKeys-1:0] map);
      return (map != '0) && ((map & (map - 1'b1)) == '0);
   endfunction

   // Position of the set bit; only meaningful when the map is one-hot.
   function automatic logic [3:0] onehot_idx(input logic [KypdKeys-1:0] map);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < KypdKeys; i++) begin
         if (map[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/marin_keypad_scan_if.sv
// Key event handshake between the keypad scanner (master) and the core (slave).
//   key       : hex code of the pending press, stable while key_valid is high
//   key_valid : press event pending
//   key_ready : consumer accepts; event consumed on an edge with valid & ready
interface marin_keypad_scan_if;

   logic [3:0] key;
   logic       key_valid;
   logic       key_ready;

   modport master (
      output key,
      output key_valid,
      input  key_ready
   );

   modport slave (
      input  key,
      input  key_valid,
      output key_ready
   );

endinterface

// File: rtl/marin_kypd_debounce.sv
// Whole-keypad debouncer.
// Compares each full-scan candidate map against the previous one, counts
// consecutive identical scans (saturating) and accepts the candidate as the
// stable map once the count reaches DEBOUNCE_SCANS. Flags a press event when
// the stable map goes from empty to exactly one key.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   scan_done_i    : candidate is a complete scan this cycle
//   cand_i         : candidate key map, index = col*4 + row, active-high
//   pressed_o      : stable map has at least one key down
//   event_o        : one-cycle pulse, registered with the stable-map update
//   event_idx_o    : index of the single key that caused event_o
module marin_kypd_debounce
   import marin_keypad_scan_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                scan_done_i,
   input  logic [KypdKeys-1:0] cand_i,
   output logic                pressed_o,
   output logic                event_o,
   output logic [3:0]          event_idx_o
);

   localparam logic [3:0] CntMax    = 4'hF;
   localparam logic [3:0] CntAccept = 4'(DEBOUNCE_SCANS);

   logic [KypdKeys-1:0] last_q, last_d;
   logic [KypdKeys-1:0] stable_q, stable_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                pressed_q, pressed_d;
   logic                event_q, event_d;
   logic [3:0]          idx_q, idx_d;

   always_comb begin
      last_d   = last_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      event_d  = 1'b0;
      idx_d    = idx_q;

      if (scan_done_i) begin
         if (cand_i != last_q) begin
            last_d = cand_i;
            cnt_d  = 4'd1;
         end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 4'd1;
         end

         if ((cnt_d >= CntAccept) && (stable_q != cand_i)) begin
            stable_d = cand_i;
            // Only a press out of an idle keypad is an event.
            if ((stable_q == '0) && is_onehot(cand_i)) begin
               event_d = 1'b1;
               idx_d   = onehot_idx(cand_i);
            end
         end
      end

      pressed_d = |stable_d;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q    <= '0;
         stable_q  <= '0;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         event_q   <= 1'b0;
         idx_q     <= '0;
      end else begin
         last_q    <= last_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         event_q   <= event_d;
         idx_q     <= idx_d;
      end
   end

   assign pressed_o   = pressed_q;
   assign event_o     = event_q;
   assign event_idx_o = idx_q;

endmodule

// File: rtl/marin_keypad_scan.sv
// Pmod KYPD 4x4 hex keypad scanner.
// Drives one column low at a time for SCAN_DIV clocks, samples the
// synchronized rows at the end of each column period, debounces whole-keypad
// snapshots and delivers single-key presses as hex codes over valid/ready.
// Ports:
//   clk_i          : board clock
//   rst_n_i        : asynchronous active-low reset
//   row_i          : keypad rows, active-low, asynchronous
//   col_o          : keypad columns, active-low one-hot
//   key_if         : key/key_valid out, key_ready in
//   pressed_o      : debounced map has at least one key down
//   overflow_o     : sticky, a press event was dropped
//   overflow_clr_i : synchronous clear of overflow_o (a same-cycle set wins)
module marin_keypad_scan
   import marin_keypad_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [KypdRows-1:0]        row_i,
   output logic [KypdCols-1:0]        col_o,
   marin_keypad_scan_if.master        key_if,
   output logic                       pressed_o,
   output logic                       overflow_o,
   input  logic                       overflow_clr_i
);

   localparam int unsigned     DivW   = $clog2(SCAN_DIV);
   localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

   // Scan state
   logic [DivW-1:0]     div_q, div_d;
   logic [1:0]          col_q, col_d;
   logic [3:0]          col_drv_q, col_drv_d;
   logic [11:0]         snap_q, snap_d;   // columns 0..2; column 3 feeds the candidate directly
   logic [3:0]          row_meta_q, row_sync_q;
   logic [3:0]          rows_act;
   logic                col_tick;
   logic                scan_done;
   logic [KypdKeys-1:0] cand;

   // Debouncer results
   logic                db_pressed;
   logic                db_event;
   logic [3:0]          db_idx;

   // Handshake state
   logic [3:0]          key_q, key_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;

   assign rows_act  = ~row_sync_q;
   assign col_tick  = (div_q == DivMax);
   assign scan_done = col_tick && (col_q == 2'd3);
   assign cand      = {rows_act, snap_q};

   always_comb begin
      div_d     = div_q + DivW'(1);
      col_d     = col_q;
      col_drv_d = col_drv_q;
      snap_d    = snap_q;

      if (col_tick) begin
         div_d     = '0;
         col_d     = col_q + 2'd1;
         col_drv_d = ~(4'b0001 << col_d);
         case (col_q)
            2'd0:    snap_d[3:0]  = rows_act;
            2'd1:    snap_d[7:4]  = rows_act;
            2'd2:    snap_d[11:8] = rows_act;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_q      <= '0;
         col_q      <= '0;
         col_drv_q  <= 4'b1110;
         snap_q     <= '0;
         // Idle rows are pulled high, so the synchronizer resets to "no key".
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         div_q      <= div_d;
         col_q      <= col_d;
         col_drv_q  <= col_drv_d;
         snap_q     <= snap_d;
         row_meta_q <= row_i;
         row_sync_q <= row_meta_q;
      end
   end

   marin_kypd_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .scan_done_i (scan_done),
      .cand_i      (cand),
      .pressed_o   (db_pressed),
      .event_o     (db_event),
      .event_idx_o (db_idx)
   );

   always_comb begin
      key_d   = key_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;

      if (overflow_clr_i) ovf_d = 1'b0;

      if (db_event) begin
         // A slot being consumed this edge can take the new code directly.
         if (!valid_q || key_if.key_ready) begin
            key_d   = key_code(db_idx);
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (valid_q && key_if.key_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         key_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         key_q   <= key_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign col_o            = col_drv_q;
   assign key_if.key       = key_q;
   assign key_if.key_valid = valid_q;
   assign pressed_o        = db_pressed;
   assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_marin_keypad_scan.sv
// Directed bench for marin_keypad_scan with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// The keypad model pulls a row low while its key is held and its column is driven.
module tb_marin_keypad_scan;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        pressed;
   logic        overflow;
   logic        overflow_clr;
   logic [15:0] keys;          // held keys, index = col*4 + row

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;             // edges since reset release
   int ev_count = 0;           // rising edges of key_valid
   int hs_count = 0;           // completed handshakes
   int ev_base;
   logic vprev = 1'b0;

   marin_keypad_scan_if kif ();

   marin_keypad_scan #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .row_i          (row),
      .col_o          (col),
      .key_if         (kif),
      .pressed_o      (pressed),
      .overflow_o     (overflow),
      .overflow_clr_i (overflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      cyc   <= rst_n ? cyc + 1 : 0;
      vprev <= kif.key_valid;
      if (kif.key_valid && !vprev) ev_count <= ev_count + 1;
      if (kif.key_valid && kif.key_ready) hs_count <= hs_count + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // sel 0 waits for key_valid, sel 1 for overflow_o; an expired budget fails the check.
   task automatic wait_high(input string tag, input int sel, input int budget);
      int n;
      n = 0;
      while (n < budget && !((sel == 0) ? kif.key_valid : overflow)) begin
         tick(1);
         n++;
      end
      check(tag, 16'((sel == 0) ? kif.key_valid : overflow), 16'h1);
   endtask

   // Land just after the first edge of a scan (column 0 driven, rows not yet sampled).
   task automatic align_scan();
      while ((cyc % 16) != 1) tick(1);
   endtask

   initial begin
      rst_n        = 1'b0;
      keys         = '0;
      overflow_clr = 1'b0;
      kif.key_ready = 1'b0;

      // 1. Reset state and column walk
      tick(3);
      check("rst_col", 16'(col), 16'hE);
      check("rst_valid", 16'(kif.key_valid), 16'h0);
      check("rst_ovf", 16'(overflow), 16'h0);
      check("rst_key", 16'(kif.key), 16'h0);
      check("rst_pressed", 16'(pressed), 16'h0);
      rst_n = 1'b1;
      tick(3);
      check("walk_c0", 16'(col), 16'hE);
      tick(1);
      check("walk_c1", 16'(col), 16'hD);
      tick(4);
      check("walk_c2", 16'(col), 16'hB);
      tick(4);
      check("walk_c3", 16'(col), 16'h7);
      tick(4);
      check("walk_wrap", 16'(col), 16'hE);

      // 2. Key '5' with a ready consumer
      keys[5] = 1'b1;
      wait_high("k5_valid", 0, 100);
      check("k5_code", 16'(kif.key), 16'h5);
      check("k5_pressed", 16'(pressed), 16'h1);
      kif.key_ready = 1'b1;
      tick(1);
      check("k5_consumed", 16'(kif.key_valid), 16'h0);
      check("k5_hs", 16'(hs_count), 16'd1);
      tick(40);
      check("k5_no_repeat", 16'(kif.key_valid), 16'h0);
      keys = '0;
      tick(64);
      check("k5_released", 16'(pressed), 16'h0);
      check("k5_one_event", 16'(ev_count), 16'd1);

      // 3. 'D' left pending, then '0' overflows
      kif.key_ready = 1'b0;
      keys[15] = 1'b1;
      wait_high("kd_valid", 0, 100);
      check("kd_code", 16'(kif.key), 16'hD);
      keys = '0;
      tick(64);
      check("kd_hold_valid", 16'(kif.key_valid), 16'h1);
      check("kd_no_ovf", 16'(overflow), 16'h0);
      keys[3] = 1'b1;
      wait_high("k0_ovf", 1, 100);
      check("k0_key_kept", 16'(kif.key), 16'hD);
      check("k0_valid_kept", 16'(kif.key_valid), 16'h1);
      overflow_clr = 1'b1;
      tick(1);
      overflow_clr = 1'b0;
      check("ovf_cleared", 16'(overflow), 16'h0);
      kif.key_ready = 1'b1;
      tick(1);
      kif.key_ready = 1'b0;
      check("kd_drained", 16'(kif.key_valid), 16'h0);
      keys = '0;
      tick(64);
      check("k0_released", 16'(pressed), 16'h0);

      // 4. Bouncing '7': alternating snapshots, then held
      ev_base = ev_count;
      align_scan();
      for (int i = 0; i < 48; i++) begin
         keys[2] = ((i / 3) % 2) == 0;
         tick(1);
      end
      keys[2] = 1'b1;
      check("k7_bounce_valid", 16'(kif.key_valid), 16'h0);
      check("k7_bounce_events", 16'(ev_count), 16'(ev_base));
      tick(15);
      check("k7_not_yet", 16'(kif.key_valid), 16'h0);
      tick(1);
      check("k7_valid", 16'(kif.key_valid), 16'h1);
      check("k7_code", 16'(kif.key), 16'h7);
      kif.key_ready = 1'b1;
      tick(1);
      kif.key_ready = 1'b0;
      check("k7_one_event", 16'(ev_count), 16'(ev_base + 1));
      keys = '0;
      tick(64);

      // 5. '1' and '2' together, then release '2'
      kif.key_ready = 1'b1;
      ev_base = ev_count;
      align_scan();
      keys = 16'h0011;
      tick(64);
      check("k12_pressed", 16'(pressed), 16'h1);
      check("k12_no_event", 16'(ev_count), 16'(ev_base));
      keys = 16'h0001;
      tick(64);
      check("k1_pressed", 16'(pressed), 16'h1);
      check("k1_no_event", 16'(ev_count), 16'(ev_base));
      keys = '0;
      tick(64);
      check("k1_released", 16'(pressed), 16'h0);
      kif.key_ready = 1'b0;

      // 6. Reset in column 2 while '9' is debouncing
      align_scan();
      keys[10] = 1'b1;
      tick(24);
      check("k9_mid_col2", 16'(col), 16'hB);
      rst_n = 1'b0;
      #1;
      check("k9_rst_col", 16'(col), 16'hE);
      check("k9_rst_key", 16'(kif.key), 16'h0);
      check("k9_rst_valid", 16'(kif.key_valid), 16'h0);
      check("k9_rst_ovf", 16'(overflow), 16'h0);
      check("k9_rst_pressed", 16'(pressed), 16'h0);
      tick(2);
      rst_n = 1'b1;
      tick(32);
      check("k9_fresh_debounce", 16'(kif.key_valid), 16'h0);
      tick(1);
      check("k9_valid", 16'(kif.key_valid), 16'h1);
      check("k9_code", 16'(kif.key), 16'h9);
      kif.key_ready = 1'b1;
      tick(1);
      kif.key_ready = 1'b0;
      keys = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
